// File: rtl/s3_chien_forney.sv
// Chien search and Forney error-magnitude evaluator for a t<=2 Reed-Solomon decoder over GF(2^8), poly 0x11D.
// Optional build macro CHIEN_FAIL_CHK_EN enables the uncorrectable-codeword check driving dec_fail.
module s3_chien_forney #(
  parameter int N = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       kes_done,
  input  logic [7:0] rs_lambda0,
  input  logic [7:0] rs_lambda1,
  input  logic [7:0] rs_lambda2,
  input  logic [7:0] rs_omega0,
  input  logic [7:0] rs_omega1,
  output logic       err_valid,
  output logic [7:0] err_pos,
  output logic       err_loc,
  output logic [7:0] err_val,
  output logic       cf_done,
  output logic [1:0] err_cnt,
  output logic       dec_fail
);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? sh : 8'h00);
      sh  = gf_xtime(sh);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for nonzero a; maps 0 to 0, which makes a zero lambda1 yield a zero magnitude
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) begin
      r = gf_xtime(r);
    end
    return r;
  endfunction

  localparam int         K0    = 256 - N;
  localparam logic [7:0] A_K0  = gf_pow(K0);
  localparam logic [7:0] A_2K0 = gf_pow((2 * K0) % 255);
  localparam logic [7:0] NM1   = 8'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_l0;
  logic [7:0] r_l1;
  logic [7:0] r_l2;
  logic [7:0] r_w0;
  logic [7:0] r_w1;
  logic [7:0] r_inv_l1;
  logic [7:0] r_pos;
  logic [1:0] r_cnt;

  logic       w_lam_zero;
  logic       w_root;
  logic [7:0] w_val;
  logic [1:0] w_cnt_nxt;

  // Evaluate Lambda and Omega at the current x; scaling by nonzero powers keeps zero terms zero
  always_comb begin
    w_lam_zero = 1'b0;
    w_root     = 1'b0;
    w_val      = 8'h00;
    w_cnt_nxt  = r_cnt;
    w_lam_zero = ((r_l0 | r_l1 | r_l2) == 8'h00);
    w_root     = ((r_l0 ^ r_l1 ^ r_l2) == 8'h00) && !w_lam_zero;
    w_val      = gf_mul(r_w0 ^ r_w1, r_inv_l1);
    if (w_root && (r_cnt != 2'd3)) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Control FSM, term registers and registered result stream
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_l0      <= 8'h00;
      r_l1      <= 8'h00;
      r_l2      <= 8'h00;
      r_w0      <= 8'h00;
      r_w1      <= 8'h00;
      r_inv_l1  <= 8'h00;
      r_pos     <= 8'h00;
      r_cnt     <= 2'd0;
      err_valid <= 1'b0;
      err_pos   <= 8'h00;
      err_loc   <= 1'b0;
      err_val   <= 8'h00;
      cf_done   <= 1'b0;
      err_cnt   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          err_valid <= 1'b0;
          err_pos   <= 8'h00;
          err_loc   <= 1'b0;
          err_val   <= 8'h00;
          cf_done   <= 1'b0;
          if (kes_done) begin
            r_state  <= S_RUN;
            r_l0     <= rs_lambda0;
            r_l1     <= gf_mul(rs_lambda1, A_K0);
            r_l2     <= gf_mul(rs_lambda2, A_2K0);
            r_w0     <= rs_omega0;
            r_w1     <= gf_mul(rs_omega1, A_K0);
            r_inv_l1 <= gf_inv(rs_lambda1);
            r_pos    <= NM1;
            r_cnt    <= 2'd0;
            err_cnt  <= 2'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          err_valid <= 1'b1;
          err_pos   <= r_pos;
          err_loc   <= w_root;
          err_val   <= w_root ? w_val : 8'h00;
          cf_done   <= 1'b0;
          r_cnt     <= w_cnt_nxt;
          r_l1      <= gf_xtime(r_l1);
          r_w1      <= gf_xtime(r_w1);
          r_l2      <= gf_xtime(gf_xtime(r_l2));
          if (r_pos == 8'h00) begin
            r_state <= S_FIN;
          end else begin
            r_pos <= r_pos - 8'd1;
          end
        end
        S_FIN: begin
          err_valid <= 1'b0;
          err_pos   <= 8'h00;
          err_loc   <= 1'b0;
          err_val   <= 8'h00;
          cf_done   <= 1'b1;
          err_cnt   <= r_cnt;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          err_valid <= 1'b0;
          err_pos   <= 8'h00;
          err_loc   <= 1'b0;
          err_val   <= 8'h00;
          cf_done   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHIEN_FAIL_CHK_EN
  logic       r_l1z_hit;
  logic       r_dec_fail;
  logic [1:0] w_deg;

  // Degree of Lambda, from the zeroness of the stepped terms
  always_comb begin
    w_deg = 2'd0;
    if (r_l2 != 8'h00) begin
      w_deg = 2'd2;
    end else if (r_l1 != 8'h00) begin
      w_deg = 2'd1;
    end else begin
      w_deg = 2'd0;
    end
  end

  // Uncorrectable flag: root count vs degree, null locator, or a root with no derivative
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_l1z_hit  <= 1'b0;
      r_dec_fail <= 1'b0;
    end else if ((r_state == S_IDLE) && kes_done) begin
      r_l1z_hit  <= 1'b0;
      r_dec_fail <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_l1z_hit <= r_l1z_hit | (w_root & (r_inv_l1 == 8'h00));
    end else if (r_state == S_FIN) begin
      r_dec_fail <= w_lam_zero | (r_cnt != w_deg) | r_l1z_hit;
    end else begin
      r_l1z_hit  <= r_l1z_hit;
      r_dec_fail <= r_dec_fail;
    end
  end

  assign dec_fail = r_dec_fail;
`else
  assign dec_fail = 1'b0;
`endif

endmodule

// File: tb/tb_s3_chien_forney.sv
// Self-checking bench for s3_chien_forney: N=255 and N=15 instances, directed table plus randomized codewords.
module tb_s3_chien_forney;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       kes;
  logic       sel;
  logic [7:0] l0, l1, l2, w0, w1;
  logic       kes_a, kes_b;
  logic       a_valid, a_loc, a_done, a_fail;
  logic [7:0] a_pos, a_val;
  logic [1:0] a_cnt;
  logic       b_valid, b_loc, b_done, b_fail;
  logic [7:0] b_pos, b_val;
  logic [1:0] b_cnt;
  logic       o_valid, o_loc, o_done, o_fail;
  logic [7:0] o_pos, o_val;
  logic [1:0] o_cnt;

  assign kes_a   = kes & ~sel;
  assign kes_b   = kes & sel;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_loc   = sel ? b_loc   : a_loc;
  assign o_done  = sel ? b_done  : a_done;
  assign o_fail  = sel ? b_fail  : a_fail;
  assign o_pos   = sel ? b_pos   : a_pos;
  assign o_val   = sel ? b_val   : a_val;
  assign o_cnt   = sel ? b_cnt   : a_cnt;

  s3_chien_forney #(.N(255)) u_a (
    .clk(clk), .rstn(rstn), .kes_done(kes_a),
    .rs_lambda0(l0), .rs_lambda1(l1), .rs_lambda2(l2), .rs_omega0(w0), .rs_omega1(w1),
    .err_valid(a_valid), .err_pos(a_pos), .err_loc(a_loc), .err_val(a_val),
    .cf_done(a_done), .err_cnt(a_cnt), .dec_fail(a_fail)
  );

  s3_chien_forney #(.N(15)) u_b (
    .clk(clk), .rstn(rstn), .kes_done(kes_b),
    .rs_lambda0(l0), .rs_lambda1(l1), .rs_lambda2(l2), .rs_omega0(w0), .rs_omega1(w1),
    .err_valid(b_valid), .err_pos(b_pos), .err_loc(b_loc), .err_val(b_val),
    .cf_done(b_done), .err_cnt(b_cnt), .dec_fail(b_fail)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Log/antilog tables for the reference model
  logic [7:0] exp_t [0:509];
  int         log_t [0:255];

  logic [7:0] m_val [0:254];
  logic       m_loc [0:254];
  int         m_cnt;
  logic       m_fail;
  logic       m_fail_eff;

  int         obs_cnt, obs_pos;
  logic       obs_fail;
  logic [7:0] obs_val;

  typedef struct {
    logic       s;
    logic [7:0] l0, l1, l2, w0, w1;
    int         cnt;
    logic       fail;
    int         pos;
    logic [7:0] val;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic ok, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    return exp_t[(255 - log_t[a]) % 255];
  endfunction

  function automatic logic fail_gate(input logic f);
`ifdef CHIEN_FAIL_CHK_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  // Reference: position p is an error iff Lambda(alpha^-p)=0, magnitude Omega/lambda1 there
  task automatic model(input int n, input logic [7:0] a0, a1, a2, b0, b1);
    logic [7:0] x, ev;
    int deg;
    logic zero, l1z_root;
    zero = (a0 == 8'h00) && (a1 == 8'h00) && (a2 == 8'h00);
    deg = (a2 != 8'h00) ? 2 : ((a1 != 8'h00) ? 1 : 0);
    m_cnt = 0;
    l1z_root = 1'b0;
    for (int p = 0; p < 255; p++) begin
      m_loc[p] = 1'b0;
      m_val[p] = 8'h00;
    end
    for (int p = 0; p < n; p++) begin
      x  = exp_t[(255 - p) % 255];
      ev = a0 ^ gmul(a1, x) ^ gmul(a2, gmul(x, x));
      if (ev == 8'h00 && !zero) begin
        m_loc[p] = 1'b1;
        m_val[p] = gmul(b0 ^ gmul(b1, x), ginv(a1));
        if (m_cnt < 3) m_cnt++;
        if (a1 == 8'h00) l1z_root = 1'b1;
      end
    end
    m_fail = zero || (m_cnt != deg) || l1z_root;
    m_fail_eff = fail_gate(m_fail);
  endtask

  task automatic run_cw(input logic s, input logic [7:0] a0, a1, a2, b0, b1,
                        input int repulse_at, input int abort_at);
    int n, p, bad;
    n = s ? 15 : 255;
    model(n, a0, a1, a2, b0, b1);
    obs_pos = -1;
    obs_val = 8'h00;
    @(negedge clk);
    sel = s; l0 = a0; l1 = a1; l2 = a2; w0 = b0; w1 = b1; kes = 1'b1;
    @(negedge clk);
    kes = 1'b0;
    check("latency", o_valid == 1'b0 && o_done == 1'b0,
          $sformatf("got valid=%0b done=%0b, need 0/0 on first cycle", o_valid, o_done));
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      p = n - 1 - j;
      check("stream", o_valid == 1'b1 && o_pos == 8'(p) && o_loc == m_loc[p] && o_val == m_val[p] && o_done == 1'b0,
            $sformatf("N=%0d p=%0d got valid=%0b pos=%0d loc=%0b val=%02h done=%0b, need 1/%0d/%0b/%02h/0",
                      n, p, o_valid, o_pos, o_loc, o_val, o_done, p, m_loc[p], m_val[p]));
      if (o_loc && obs_pos < 0) begin
        obs_pos = o_pos;
        obs_val = o_val;
      end
      if (j == abort_at) begin
        rstn = 1'b0;
        @(negedge clk);
        check("reset_clear", {a_valid, a_loc, a_done, a_fail, a_pos, a_val, a_cnt} == '0,
              $sformatf("got valid=%0b pos=%0d loc=%0b val=%02h done=%0b cnt=%0d fail=%0b, need all 0",
                        a_valid, a_pos, a_loc, a_val, a_done, a_cnt, a_fail));
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
          @(negedge clk);
          if (o_valid || o_done) bad++;
        end
        check("abort_quiet", bad == 0, $sformatf("got %0d active cycles after abort, need 0", bad));
        return;
      end
      kes = (j == repulse_at);
      if (j == repulse_at) begin
        l0 = 8'h01; l1 = 8'h5A; l2 = 8'h33; w0 = 8'hC3; w1 = 8'h11;
      end
    end
    @(negedge clk);
    kes = 1'b0;
    check("cf_done", o_done == 1'b1 && o_valid == 1'b0 && o_pos == 8'h00 && o_loc == 1'b0 && o_val == 8'h00 &&
          o_cnt == 2'(m_cnt) && o_fail == m_fail_eff,
          $sformatf("got done=%0b valid=%0b pos=%0d cnt=%0d fail=%0b, need 1/0/0/%0d/%0b",
                    o_done, o_valid, o_pos, o_cnt, o_fail, m_cnt, m_fail_eff));
    obs_cnt  = o_cnt;
    obs_fail = o_fail;
    @(negedge clk);
    check("hold", o_done == 1'b0 && o_valid == 1'b0 && o_cnt == 2'(m_cnt) && o_fail == m_fail_eff,
          $sformatf("got done=%0b valid=%0b cnt=%0d fail=%0b, need 0/0/%0d/%0b",
                    o_done, o_valid, o_cnt, o_fail, m_cnt, m_fail_eff));
  endtask

  initial begin
    logic [7:0] v;
    logic s;
    logic [7:0] x1, x2;
    int n, p1, p2, mode;

    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    end
    for (int i = 255; i < 510; i++) exp_t[i] = exp_t[i - 255];
    log_t[0] = 0;

    vt[0] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, -1, 8'h00};
    vt[1] = '{1'b0, 8'h01, 8'h74, 8'h00, 8'h74, 8'h00, 1, 1'b0, 10, 8'h01};
    vt[2] = '{1'b0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1, 1'b1, 0,  8'h00};
    vt[3] = '{1'b1, 8'h01, 8'h02, 8'h00, 8'h02, 8'h00, 1, 1'b0, 1,  8'h01};
    vt[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 0, 1'b1, -1, 8'h00};
    vt[5] = '{1'b0, 8'h01, 8'hBC, 8'hC9, 8'hBC, 8'h00, 2, 1'b0, 20, 8'h01};

    rstn = 1'b0; kes = 1'b0; sel = 1'b0;
    l0 = 8'h00; l1 = 8'h00; l2 = 8'h00; w0 = 8'h00; w1 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {a_valid, a_loc, a_done, a_fail, a_pos, a_val, a_cnt,
                          b_valid, b_loc, b_done, b_fail, b_pos, b_val, b_cnt} == '0,
          $sformatf("got a: v=%0b done=%0b cnt=%0d b: v=%0b done=%0b cnt=%0d, need all 0",
                    a_valid, a_done, a_cnt, b_valid, b_done, b_cnt));
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_cw(vt[i].s, vt[i].l0, vt[i].l1, vt[i].l2, vt[i].w0, vt[i].w1, -1, -1);
      check("tbl_cnt", obs_cnt == vt[i].cnt, $sformatf("vec %0d got %0d need %0d", i, obs_cnt, vt[i].cnt));
      check("tbl_fail", obs_fail == fail_gate(vt[i].fail),
            $sformatf("vec %0d got %0b need %0b", i, obs_fail, fail_gate(vt[i].fail)));
      check("tbl_root", obs_pos == vt[i].pos && (vt[i].pos < 0 || obs_val == vt[i].val),
            $sformatf("vec %0d got pos=%0d val=%02h need pos=%0d val=%02h", i, obs_pos, obs_val, vt[i].pos, vt[i].val));
    end

    // kes_done re-pulsed in RUN, then in FIN, then on the short code
    run_cw(1'b0, 8'h01, 8'h74, 8'h00, 8'h74, 8'h00, 50, -1);
    run_cw(1'b0, 8'h01, 8'hBC, 8'hC9, 8'hBC, 8'h00, 254, -1);
    run_cw(1'b1, 8'h01, 8'h02, 8'h00, 8'h02, 8'h00, 5, -1);

    // Reset at valid cycle 100, then a clean codeword
    run_cw(1'b0, 8'h01, 8'h74, 8'h00, 8'h74, 8'h00, -1, 99);
    run_cw(1'b0, 8'h01, 8'h74, 8'h00, 8'h74, 8'h00, -1, -1);

    for (int r = 0; r < 20; r++) begin
      s = ($urandom_range(0, 3) == 0);
      n = s ? 15 : 255;
      mode = $urandom_range(0, 2);
      p1 = $urandom_range(0, n - 1);
      p2 = (p1 + $urandom_range(1, n - 1)) % n;
      x1 = exp_t[p1];
      x2 = exp_t[p2];
      if (mode == 0) begin
        run_cw(s, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
      end else if (mode == 1) begin
        run_cw(s, 8'h01, x1, 8'h00, 8'($urandom), 8'($urandom), -1, -1);
      end else begin
        run_cw(s, 8'h01, x1 ^ x2, gmul(x1, x2), 8'($urandom), 8'($urandom), -1, -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
